salsa_engine: RTL and testbench



---
 rtl/salsa_pkg.sv | 30 +++
 rtl/salsa_dround.sv | 58 +++++
 rtl/salsa_engine.sv | 116 +++++++++++
 tb/tb_salsa_engine.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/salsa_pkg.sv
// Shared constants, types and helpers for the Salsa20/R block-mix engine.
package salsa_pkg;

  localparam int WORD_W = 32;
  localparam int NWORDS = 16;
  localparam int BLK_W  = 512;

  // Quarter-round left-rotation amounts, in order of application.
  localparam int ROT_A = 7;
  localparam int ROT_B = 9;
  localparam int ROT_C = 13;
  localparam int ROT_D = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // 32-bit rotate left by a constant amount (0 < n < 32).
  function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] v, input int n);
    return (v << n) | (v >> (WORD_W - n));
  endfunction

  // Low bit index of word i inside a 512-bit block.
  function automatic int wlo(input int i);
    return i * WORD_W;
  endfunction

endpackage

// File: rtl/salsa_dround.sv
// One Salsa20 double-round (column round then row round), purely combinational.
module salsa_dround
  import salsa_pkg::*;
(
  input  logic [BLK_W-1:0] din,
  output logic [BLK_W-1:0] dout
);

  // Quarter-round on (a,b,c,d); returns {a,b,c,d} updated.
  function automatic logic [4*WORD_W-1:0] qr(input logic [WORD_W-1:0] a,
                                             input logic [WORD_W-1:0] b,
                                             input logic [WORD_W-1:0] c,
                                             input logic [WORD_W-1:0] d);
    logic [WORD_W-1:0] a1, b1, c1, d1;
    b1 = b ^ rotl32(a + d, ROT_A);
    c1 = c ^ rotl32(b1 + a, ROT_B);
    d1 = d ^ rotl32(c1 + b1, ROT_C);
    a1 = a ^ rotl32(d1 + c1, ROT_D);
    return {a1, b1, c1, d1};
  endfunction

  logic [WORD_W-1:0] w_in  [NWORDS];
  logic [WORD_W-1:0] w_col [NWORDS];
  logic [WORD_W-1:0] w_row [NWORDS];

  genvar gi;

  // Unpack input words and repack the row-round result.
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_words
      localparam int LO = wlo(gi);
      assign w_in[gi]            = din[LO +: WORD_W];
      assign dout[LO +: WORD_W]  = w_row[gi];
    end
  endgenerate

  // Column j works on words (5j, 5j+4, 5j+8, 5j+12) mod 16; row j starts at
  // the diagonal word 5j and walks the rest of row j cyclically.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_qr
      localparam int CA = (5 * gi) % 16;
      localparam int CB = (5 * gi + 4) % 16;
      localparam int CC = (5 * gi + 8) % 16;
      localparam int CD = (5 * gi + 12) % 16;
      localparam int RA = 5 * gi;
      localparam int RB = 4 * gi + (gi + 1) % 4;
      localparam int RC = 4 * gi + (gi + 2) % 4;
      localparam int RD = 4 * gi + (gi + 3) % 4;

      assign {w_col[CA], w_col[CB], w_col[CC], w_col[CD]} =
        qr(w_in[CA], w_in[CB], w_in[CC], w_in[CD]);

      assign {w_row[RA], w_row[RB], w_row[RC], w_row[RD]} =
        qr(w_col[RA], w_col[RB], w_col[RC], w_col[RD]);
    end
  endgenerate

endmodule

// File: rtl/salsa_engine.sv
// Salsa20/R block-mix engine: Bo = X + SalsaR(X), X = B ^ Bx, with
// valid/ready handshakes and a registered, back-pressure-held result.
module salsa_engine
  import salsa_pkg::*;
#(
  parameter int ROUNDS = 8,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] B,
  input  logic [BLK_W-1:0] Bx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] Bo
);

  localparam int ITER  = ROUNDS / (2 * UNROLL);
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  // Reject parameter sets that cannot be split into whole core clocks.
  generate
    if (UNROLL < 1 || ROUNDS < 2 || (ROUNDS % 2) != 0 || ((ROUNDS / 2) % UNROLL) != 0) begin : g_bad_param
      $error("salsa_engine: ROUNDS must be even, >= 2, and ROUNDS/2 divisible by UNROLL");
    end
  endgenerate

  state_t            state_reg, state_next;
  logic [BLK_W-1:0]  x_reg, xx_reg, bo_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              out_valid_reg;
  logic              last_iter;

  logic [BLK_W-1:0]  chain [UNROLL+1];
  logic [BLK_W-1:0]  mix_sum;

  genvar gi;

  // UNROLL double-rounds chained combinationally each core clock.
  assign chain[0] = x_reg;
  generate
    for (gi = 0; gi < UNROLL; gi++) begin : g_unroll
      salsa_dround u_dround (
        .din  (chain[gi]),
        .dout (chain[gi+1])
      );
    end
  endgenerate

  // Final feed-forward: per-word add mod 2^32 of the saved X.
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_sum
      localparam int LO = wlo(gi);
      assign mix_sum[LO +: WORD_W] = xx_reg[LO +: WORD_W] + chain[UNROLL][LO +: WORD_W];
    end
  endgenerate

  assign last_iter = (state_reg == RUN) && (cnt_reg == CNT_LAST);
  assign out_valid = out_valid_reg;
  assign Bo        = bo_reg;

  // Next-state and handshake decode.
  always_comb begin
    state_next = state_reg;
    in_ready   = (state_reg == IDLE);
    case (state_reg)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_iter) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Datapath: load X, iterate double-rounds, latch result and valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg         <= '0;
      xx_reg        <= '0;
      cnt_reg       <= '0;
      bo_reg        <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            x_reg   <= B ^ Bx;
            xx_reg  <= B ^ Bx;
            cnt_reg <= '0;
          end
        end
        RUN: begin
          x_reg   <= chain[UNROLL];
          cnt_reg <= cnt_reg + 1'b1;
          if (last_iter) begin
            bo_reg        <= mix_sum;
            out_valid_reg <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_salsa_engine.sv
// Directed bench for salsa_engine: RFC 7914 Salsa20/8 vector across UNROLL
// variants, cancel case, back-pressure, mid-run reset and back-to-back blocks.
module tb_salsa_engine;

  logic         clk;
  logic         reset;
  logic [2:0]   iv;
  logic [2:0]   orr;
  logic [511:0] b_in, bx_in;
  logic         ir   [3];
  logic         ov   [3];
  logic [511:0] bo_q [3];

  int n_vec = 0;
  int n_err = 0;

  logic [511:0] rfc_in, rfc_out, pad_a5, dead;

  salsa_engine #(.ROUNDS(8), .UNROLL(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .B(b_in), .Bx(bx_in),
    .out_valid(ov[0]), .out_ready(orr[0]), .Bo(bo_q[0]));
  salsa_engine #(.ROUNDS(8), .UNROLL(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .B(b_in), .Bx(bx_in),
    .out_valid(ov[1]), .out_ready(orr[1]), .Bo(bo_q[1]));
  salsa_engine #(.ROUNDS(8), .UNROLL(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .B(b_in), .Bx(bx_in),
    .out_valid(ov[2]), .out_ready(orr[2]), .Bo(bo_q[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one block on engine w, check latency, result and handshake release.
  task automatic run_block(input int w, input logic [511:0] b, input logic [511:0] bx,
                           input int lat, input logic [511:0] exp, input string tag);
    b_in  = b;
    bx_in = bx;
    chk({tag, "_ready_before"}, {511'd0, ir[w]}, 512'd1);
    iv[w] = 1'b1;
    step();
    iv[w] = 1'b0;
    chk({tag, "_ready_busy"}, {511'd0, ir[w]}, 512'd0);
    for (int k = 1; k < lat; k++) begin
      step();
      chk({tag, "_early_valid"}, {511'd0, ov[w]}, 512'd0);
    end
    step();
    chk({tag, "_valid"}, {511'd0, ov[w]}, 512'd1);
    chk({tag, "_bo"}, bo_q[w], exp);
    orr[w] = 1'b1;
    step();
    orr[w] = 1'b0;
    chk({tag, "_valid_drop"}, {511'd0, ov[w]}, 512'd0);
    chk({tag, "_ready_back"}, {511'd0, ir[w]}, 512'd1);
    chk({tag, "_bo_kept"}, bo_q[w], exp);
    $display("txn %s: engine %0d latency %0d Bo[31:0]=%08h", tag, w, lat, bo_q[w][31:0]);
  endtask

  initial begin
    int gap;
    logic seen;

    rfc_in  = {32'h5ec2b8b8, 32'h8dc6ebed, 32'h2948c709, 32'h291d0276,
               32'h32aac55a, 32'h4b1e1214, 32'h853d9bdf, 32'h19f324ee,
               32'h1d3bcd6d, 32'h1146f80d, 32'hb5c1618c, 32'h5b55eeba,
               32'h268f7141, 32'he640a97c, 32'h86c93e4f, 32'h219a877e};
    rfc_out = {32'h818f61c7, 32'h3d67ad24, 32'h5c74912c, 32'h10cc24e4,
               32'hba966da0, 32'hb7c56bfe, 32'hbce6c9e3, 32'h683139b4,
               32'h292f6896, 32'h631c7bfd, 32'h7d33fda2, 32'h81214b04,
               32'h05ef0c02, 32'hcbca813b, 32'h99cc0866, 32'h9c851fa4};
    pad_a5  = {64{8'hA5}};
    dead    = {16{32'hDEADBEEF}};

    reset = 1'b1;
    iv    = 3'b000;
    orr   = 3'b000;
    b_in  = '0;
    bx_in = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_ready",  {511'd0, ir[0]}, 512'd1);
    chk("rst_valid",  {511'd0, ov[0]}, 512'd0);
    chk("rst_bo",     bo_q[0], 512'd0);
    chk("rst_ready4", {511'd0, ir[2]}, 512'd1);
    $display("txn reset: engines idle");

    // RFC vector and split variants on each unroll factor
    run_block(0, rfc_in, 512'd0, 4, rfc_out, "rfc_u1");
    run_block(1, rfc_in ^ pad_a5, pad_a5, 2, rfc_out, "split_u2");
    run_block(2, rfc_in ^ pad_a5, pad_a5, 1, rfc_out, "split_u4");

    // Cancel case
    run_block(0, dead, dead, 4, 512'd0, "cancel_u1");

    // Back-pressure: hold result for 10 cycles while inputs churn
    b_in  = rfc_in;
    bx_in = '0;
    iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("bp_valid", {511'd0, ov[0]}, 512'd1);
    for (int k = 0; k < 10; k++) begin
      iv[0] = ~iv[0];
      b_in  = {16{$urandom}};
      bx_in = {16{$urandom}};
      step();
      chk("bp_bo_stable", bo_q[0], rfc_out);
      chk("bp_ready_low", {511'd0, ir[0]}, 512'd0);
      chk("bp_valid_held", {511'd0, ov[0]}, 512'd1);
    end
    iv[0]  = 1'b0;
    orr[0] = 1'b1;
    step();
    orr[0] = 1'b0;
    chk("bp_release_valid", {511'd0, ov[0]}, 512'd0);
    chk("bp_release_ready", {511'd0, ir[0]}, 512'd1);
    $display("txn backpressure: held 10 cycles, Bo[31:0]=%08h", bo_q[0][31:0]);
    run_block(0, rfc_in ^ pad_a5, pad_a5, 4, rfc_out, "after_bp");

    // Reset mid-RUN at cnt == 2
    b_in  = dead;
    bx_in = '0;
    iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_valid", {511'd0, ov[0]}, 512'd0);
    chk("midrst_bo",    bo_q[0], 512'd0);
    chk("midrst_ready", {511'd0, ir[0]}, 512'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("midrst_no_pulse", {511'd0, ov[0]}, 512'd0);
    end
    $display("txn midrun_reset: computation discarded");
    run_block(0, rfc_in, 512'd0, 4, rfc_out, "after_rst");

    // Back-to-back with out_ready tied high
    orr[0] = 1'b1;
    b_in   = dead;
    bx_in  = dead;
    iv[0]  = 1'b1;
    step();
    b_in   = rfc_in;
    bx_in  = '0;
    gap    = 0;
    seen   = 1'b0;
    while (gap < 20 && !ir[0]) begin
      step();
      gap++;
      if (ov[0]) begin
        seen = 1'b1;
        chk("b2b_first_bo", bo_q[0], 512'd0);
      end
    end
    chk("b2b_first_seen", {511'd0, seen}, 512'd1);
    step();
    gap++;
    iv[0] = 1'b0;
    chk("b2b_spacing", 512'(gap), 512'd6);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (ov[0]) seen = 1'b1;
    end
    chk("b2b_second_seen", {511'd0, seen}, 512'd1);
    chk("b2b_second_bo", bo_q[0], rfc_out);
    step();
    orr[0] = 1'b0;
    chk("b2b_end_ready", {511'd0, ir[0]}, 512'd1);
    $display("txn back_to_back: spacing %0d cycles", gap);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
